// File: rtl/program_loader_pkg.sv
// loader_pkg: shared state type and framing constants for the program loader.
package loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} loader_state_t;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int LEN_BYTES = 4;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: UART receive handshake, program memory write port and CPU control.
interface program_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        write_enable;
    logic [7:0]  write_data;
    logic [31:0] write_address;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, write_enable, write_data, write_address, cpu_hold, load_done, load_error
    );
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, write_enable, write_data, write_address, cpu_hold, load_done, load_error
    );
endinterface

// File: rtl/program_loader_timeout_counter.sv
// loader_timeout_counter: idle-gap counter; expired_o flags the last allowed idle cycle.
module loader_timeout_counter #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = $clog2(CYCLES + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (clear_i || !en_i) ? '0 : cnt_q + W'(1);
    assign expired_o = en_i && !clear_i && cnt_q == W'(CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: parses SYNC/length/payload frames into program memory and gates CPU reset.
// Optional trailing checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int         MEM_BYTES      = 1024,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.slave bus
);
    localparam int AW = $clog2(MEM_BYTES) + 1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_PAYLOAD = CSUM;
    logic [7:0] sum_q, sum_d;
`else
    localparam loader_state_t AFTER_PAYLOAD = DONE;
`endif
    loader_state_t state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   len_q, len_d, len_full;
    logic [AW-1:0] cnt_q, cnt_d, waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          we_q, we_d, hold_q, hold_d, err_q, err_d;
    logic          accept, active, expired;

    assign bus.rx_ready      = state_q inside {IDLE, LEN, DATA, CSUM};
    assign bus.write_enable  = we_q;
    assign bus.write_data    = wdata_q;
    assign bus.write_address = 32'(waddr_q);
    assign bus.cpu_hold      = hold_q;
    assign bus.load_done     = state_q == DONE;
    assign bus.load_error    = err_q;
    assign accept   = bus.rx_valid && bus.rx_ready;
    assign active   = state_q inside {LEN, DATA, CSUM};
    // length arrives little-endian, so each byte shifts in from the top
    assign len_full = {bus.rx_data, len_q[31:8]};

    loader_timeout_counter #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk(clk), .rst(rst), .clear_i(accept), .en_i(active), .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        hold_d  = hold_q;
        err_d   = err_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: if (accept && bus.rx_data == SYNC_BYTE) begin
                hold_d  = 1'b1;
                err_d   = 1'b0;
                idx_d   = '0;
                cnt_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                sum_d   = '0;
`endif
                state_d = LEN;
            end
            LEN: if (accept) begin
                len_d = len_full;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'(LEN_BYTES - 1))
                    state_d = len_full > 32'(MEM_BYTES) ? ERROR : (len_full == '0 ? AFTER_PAYLOAD : DATA);
            end else if (expired) state_d = ERROR;
            DATA: if (accept) begin
                we_d    = 1'b1;
                wdata_d = bus.rx_data;
                waddr_d = cnt_q;
                cnt_d   = cnt_q + AW'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                sum_d   = sum_q + bus.rx_data;
`endif
                if (cnt_q == AW'(len_q - 32'd1)) state_d = AFTER_PAYLOAD;
            end else if (expired) state_d = ERROR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            // a correct trailer makes the running sum wrap to zero
            CSUM: if (accept) state_d = 8'(sum_q + bus.rx_data) == 8'd0 ? DONE : ERROR;
                  else if (expired) state_d = ERROR;
`endif
            DONE: begin
                hold_d  = 1'b0;
                state_d = IDLE;
            end
            ERROR: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
            hold_q  <= 1'b1;
            err_q   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
endmodule
